ov7670_dvp_emulator: RTL and testbench

//  OV7670-style DVP transmitter: reads 12-bit RGB444 pixels from a frame buffer, emits vsync/href/d

---
 rtl/ov7670_dvp_emulator.sv | 173 +++++++++++++++++
 tb/tb_ov7670_dvp_emulator.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ov7670_dvp_emulator.sv
// ov7670_dvp_emulator
//   OV7670-style DVP transmitter. Reads RGB444 pixels from a synchronous frame
//   buffer and emits a vsync/href/d byte stream as RGB565, two bytes per pixel,
//   one byte per pclk. Smaller 160x120 / 320x240 buffers are up-scaled by pixel
//   and line repetition so the output always has full line/frame timing.
//
// Ports
//   pclk        byte clock; all outputs registered
//   rst_n       asynchronous active-low reset
//   enable      start/continue frames, sampled at frame boundaries only
//   rez_160x120 buffer is (H_ACTIVE/4)x(V_ACTIVE/4), 4x4 repetition (wins over 320x240)
//   rez_320x240 buffer is (H_ACTIVE/2)x(V_ACTIVE/2), 2x2 repetition
//   rd_addr     frame-buffer read address (17 bits, wraps)
//   rd_data     {R4,G4,B4}, valid one clock after rd_addr
//   vsync       frame sync, high for the whole VSYNC period
//   href        line valid
//   d           pixel byte, zero while href is low
//   frame_done  one-clock pulse on the last clock of the front porch
module ov7670_dvp_emulator #(
    parameter int H_ACTIVE    = 640,
    parameter int H_BLANK     = 144,
    parameter int V_ACTIVE    = 480,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        rez_160x120,
    input  logic        rez_320x240,
    output logic [16:0] rd_addr,
    input  logic [11:0] rd_data,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  d,
    output logic        frame_done
);

    localparam int L    = 2 * H_ACTIVE + H_BLANK;
    localparam int HW   = $clog2(L);
    localparam int VM1  = (V_ACTIVE > VSYNC_LINES) ? V_ACTIVE : VSYNC_LINES;
    localparam int VM2  = (V_BACK > V_FRONT) ? V_BACK : V_FRONT;
    localparam int VMAX = (VM1 > VM2) ? VM1 : VM2;
    localparam int LW   = (VMAX > 4) ? $clog2(VMAX) : 2;

    localparam logic [HW-1:0] HC_LAST   = HW'(L - 1);
    localparam logic [HW-1:0] HC_PRE    = HW'(L - 2);
    localparam logic [HW-1:0] HC_RD_END = HW'(2 * H_ACTIVE - 2);
    localparam logic [HW-1:0] HC_HREF   = HW'(2 * H_ACTIVE);

    localparam logic [LW-1:0] LAST_VS  = LW'(VSYNC_LINES - 1);
    localparam logic [LW-1:0] LAST_VB  = LW'(V_BACK - 1);
    localparam logic [LW-1:0] LAST_ACT = LW'(V_ACTIVE - 1);
    localparam logic [LW-1:0] LAST_VF  = LW'(V_FRONT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_VSYNC  = 3'd1;
    localparam logic [2:0] S_VBACK  = 3'd2;
    localparam logic [2:0] S_ACTIVE = 3'd3;
    localparam logic [2:0] S_VFRONT = 3'd4;

    logic [2:0]    state, nxt_state;
    logic [HW-1:0] hcnt, nxt_hcnt;
    logic [LW-1:0] lcnt, nxt_lcnt, line_last;
    logic [1:0]    shift, nxt_shift;
    logic [16:0]   line_base, nxt_base, nxt_addr, inc;
    logic [HW-1:0] hp2, px;
    logic          frame_start, y_ones, rd_act, rd_pre;
    logic          nxt_href;
    logic [15:0]   word;

    // Position counters: state/hcnt/lcnt describe the cycle the registered
    // outputs currently present; outputs are registered from the next position.
    always_comb begin
        nxt_state = state;
        nxt_hcnt  = hcnt;
        nxt_lcnt  = lcnt;
        case (state)
            S_VSYNC:  line_last = LAST_VS;
            S_VBACK:  line_last = LAST_VB;
            S_ACTIVE: line_last = LAST_ACT;
            S_VFRONT: line_last = LAST_VF;
            default:  line_last = '0;
        endcase
        if (state == S_IDLE) begin
            if (enable)
                nxt_state = S_VSYNC;
        end else if (hcnt == HC_LAST) begin
            nxt_hcnt = '0;
            if (lcnt == line_last) begin
                nxt_lcnt = '0;
                case (state)
                    S_VSYNC:  nxt_state = S_VBACK;
                    S_VBACK:  nxt_state = S_ACTIVE;
                    S_ACTIVE: nxt_state = S_VFRONT;
                    S_VFRONT: nxt_state = enable ? S_VSYNC : S_IDLE;
                    default:  nxt_state = S_IDLE;
                endcase
            end else begin
                nxt_lcnt = lcnt + LW'(1);
            end
        end else begin
            nxt_hcnt = hcnt + HW'(1);
        end
    end

    always_comb begin
        frame_start = (nxt_state == S_VSYNC) && (state != S_VSYNC);
        if (frame_start)
            nxt_shift = rez_160x120 ? 2'd2 : (rez_320x240 ? 2'd1 : 2'd0);
        else
            nxt_shift = shift;
        inc = 17'(H_ACTIVE) >> nxt_shift;
        case (nxt_shift)
            2'd0:    y_ones = 1'b1;
            2'd1:    y_ones = nxt_lcnt[0];
            default: y_ones = &nxt_lcnt[1:0];
        endcase
        // The base advances at hcnt=L-2 rather than at end of line so the
        // look-ahead read of the next line's pixel 0 already uses it.
        if (frame_start)
            nxt_base = '0;
        else if (nxt_state == S_ACTIVE && nxt_hcnt == HC_PRE && y_ones)
            nxt_base = line_base + inc;
        else
            nxt_base = line_base;

        rd_act = (nxt_state == S_ACTIVE) && (nxt_hcnt < HC_RD_END);
        rd_pre = (nxt_hcnt >= HC_PRE) &&
                 (((nxt_state == S_VBACK) && (nxt_lcnt == LAST_VB)) ||
                  ((nxt_state == S_ACTIVE) && (nxt_lcnt != LAST_ACT)));
        // Address leads byte0 of pixel x by two clocks and is held for two.
        hp2 = nxt_hcnt + HW'(2);
        px  = rd_pre ? '0 : (hp2 >> 1);
        if (rd_act || rd_pre)
            nxt_addr = nxt_base + (17'(px) >> nxt_shift);
        else
            nxt_addr = rd_addr;

        nxt_href = (nxt_state == S_ACTIVE) && (nxt_hcnt < HC_HREF);
        word = {rd_data[11:8], rd_data[11], rd_data[7:4], rd_data[7:6],
                rd_data[3:0], rd_data[3]};
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            hcnt       <= '0;
            lcnt       <= '0;
            shift      <= '0;
            line_base  <= '0;
            rd_addr    <= '0;
            vsync      <= 1'b0;
            href       <= 1'b0;
            d          <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= nxt_state;
            hcnt       <= nxt_hcnt;
            lcnt       <= nxt_lcnt;
            shift      <= nxt_shift;
            line_base  <= nxt_base;
            rd_addr    <= nxt_addr;
            vsync      <= (nxt_state == S_VSYNC);
            href       <= nxt_href;
            d          <= nxt_href ? (nxt_hcnt[0] ? word[7:0] : word[15:8]) : '0;
            frame_done <= (nxt_state == S_VFRONT) && (nxt_lcnt == LAST_VF) &&
                          (nxt_hcnt == HC_LAST);
        end
    end

endmodule

// File: tb/tb_ov7670_dvp_emulator.sv
// tb_ov7670_dvp_emulator
//   Directed bench for ov7670_dvp_emulator with small frame parameters
//   (8 px x 4 lines, L=20, 140-clock frame) and a synchronous RAM model.
module tb_ov7670_dvp_emulator;

    localparam int FRAME = 140;

    logic        pclk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        rez_160x120;
    logic        rez_320x240;
    logic [16:0] rd_addr;
    logic [11:0] rd_data;
    logic        vsync;
    logic        href;
    logic [7:0]  d;
    logic        frame_done;

    ov7670_dvp_emulator #(
        .H_ACTIVE(8), .H_BLANK(4), .V_ACTIVE(4),
        .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)
    ) dut (
        .pclk(pclk), .rst_n(rst_n), .enable(enable),
        .rez_160x120(rez_160x120), .rez_320x240(rez_320x240),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .vsync(vsync), .href(href), .d(d), .frame_done(frame_done)
    );

    always #5 pclk = ~pclk;

    logic [11:0] mem [0:255];
    always @(posedge pclk) rd_data <= mem[rd_addr[7:0]];

    typedef struct {
        logic             r160;
        logic             r320;
        logic [11:0]      ram0;
        logic [11:0]      ram1;
        logic [1:0]       sh;
        logic [3:0][16:0] base;
        logic [7:0]       b0, b1, b2, b3;
    } vec_t;

    vec_t vecs [5];
    int checks = 0;
    int errors = 0;

    function automatic logic [15:0] enc(input logic [11:0] c);
        return {c[11:8], c[11], c[7:4], c[7:6], c[3:0], c[3]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load_mem(input int vi);
        for (int i = 0; i < 256; i++) mem[i] = 12'(i);
        mem[0] = vecs[vi].ram0;
        mem[1] = vecs[vi].ram1;
    endtask

    task automatic set_rez(input int vi);
        rez_160x120 = vecs[vi].r160;
        rez_320x240 = vecs[vi].r320;
    endtask

    // Checks one full frame starting at the negedge where vsync is first high.
    task automatic run_frame(input int vi, input bit drop_en);
        int n;
        logic [16:0] a1, a2, ea;
        logic [15:0] w;
        logic [7:0]  ed;
        logic [7:0]  hb [4];
        n = 0;
        while (vsync !== 1'b1 && n < 50) begin
            @(negedge pclk);
            n++;
        end
        chk("vsync_start", {31'd0, vsync}, 32'd1);
        load_mem(vi);
        hb[0] = vecs[vi].b0; hb[1] = vecs[vi].b1;
        hb[2] = vecs[vi].b2; hb[3] = vecs[vi].b3;
        a1 = '0;
        a2 = '0;
        for (int c = 0; c < FRAME; c++) begin
            int y, p;
            bit in_act, exp_href;
            if (c > 0) @(negedge pclk);
            in_act   = (c >= 40) && (c < 120);
            y        = (c - 40) / 20;
            p        = (c - 40) % 20;
            exp_href = in_act && (p < 16);
            chk("vsync", {31'd0, vsync}, {31'd0, c < 20});
            chk("href", {31'd0, href}, {31'd0, exp_href});
            chk("frame_done", {31'd0, frame_done}, {31'd0, c == FRAME - 1});
            if (exp_href) begin
                ea = vecs[vi].base[y] + (17'(p / 2) >> vecs[vi].sh);
                w  = enc(mem[ea[7:0]]);
                ed = (p % 2 == 1) ? w[7:0] : w[15:8];
                if (y == 0 && p < 4) ed = hb[p];
                chk("d_byte", {24'd0, d}, {24'd0, ed});
                if (p % 2 == 0) chk("rd_addr", {15'd0, a2}, {15'd0, ea});
            end else begin
                chk("d_zero", {24'd0, d}, 32'd0);
            end
            a2 = a1;
            a1 = rd_addr;
            if (c == 50) begin
                rez_160x120 = ~rez_160x120;
                rez_320x240 = ~rez_320x240;
            end
            if (c == 60 && drop_en) enable = 1'b0;
            if (c == 100) set_rez(vi);
        end
    endtask

    task automatic idle_check(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge pclk);
            chk("idle", {21'd0, vsync, href, d, frame_done}, 32'd0);
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 12'hF5A, 12'h001, 2'd0,
                    {17'd24, 17'd16, 17'd8, 17'd0}, 8'hFA, 8'hB5, 8'h00, 8'h02};
        vecs[1] = '{1'b0, 1'b1, 12'h123, 12'h001, 2'd1,
                    {17'd4, 17'd4, 17'd0, 17'd0}, 8'h11, 8'h06, 8'h11, 8'h06};
        vecs[2] = '{1'b1, 1'b1, 12'h8C7, 12'h001, 2'd2,
                    {17'd0, 17'd0, 17'd0, 17'd0}, 8'h8E, 8'h6E, 8'h8E, 8'h6E};
        vecs[3] = '{1'b1, 1'b0, 12'hFFF, 12'h001, 2'd2,
                    {17'd0, 17'd0, 17'd0, 17'd0}, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vecs[4] = '{1'b0, 1'b0, 12'h000, 12'hFFF, 2'd0,
                    {17'd24, 17'd16, 17'd8, 17'd0}, 8'h00, 8'h00, 8'hFF, 8'hFF};

        rst_n = 1'b0;
        enable = 1'b0;
        rez_160x120 = 1'b0;
        rez_320x240 = 1'b0;
        load_mem(0);
        repeat (3) @(negedge pclk);
        chk("reset_out", {14'd0, rd_addr, vsync, href, d, frame_done}, 32'd0);
        rst_n = 1'b1;
        idle_check(200);

        // One frame per vector, enable dropped mid-ACTIVE each time.
        for (int vi = 0; vi < 5; vi++) begin
            set_rez(vi);
            enable = 1'b1;
            run_frame(vi, 1'b1);
            idle_check(30);
        end

        // Back-to-back frames: next vsync directly after frame_done.
        set_rez(0);
        enable = 1'b1;
        run_frame(0, 1'b0);
        @(negedge pclk);
        chk("vsync_restart", {31'd0, vsync}, 32'd1);
        run_frame(4, 1'b1);
        idle_check(30);

        // Asynchronous reset mid-line, then a fresh frame.
        set_rez(0);
        enable = 1'b1;
        begin
            int n;
            n = 0;
            while (vsync !== 1'b1 && n < 50) begin
                @(negedge pclk);
                n++;
            end
            chk("vsync_pre_reset", {31'd0, vsync}, 32'd1);
        end
        repeat (45) @(negedge pclk);
        chk("href_pre_reset", {31'd0, href}, 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {14'd0, rd_addr, vsync, href, d, frame_done}, 32'd0);
        @(negedge pclk);
        rst_n = 1'b1;
        run_frame(0, 1'b1);
        idle_check(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
